// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_t;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } wr_req_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, as one-hot and index.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx
);

  // Scan NREQ positions starting at ptr; the first valid one wins.
  always_comb begin
    logic          found;
    logic [PW-1:0] cand;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && valid[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the regfile write port (we3/wa3/wd3) among NREQ writeback requesters.
// Optional macro REGFILE_ARB_ZERO_REG_EN: writes to address 0 are acknowledged but dropped.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             hold,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             we3,
  output logic [AW-1:0]    wa3,
  output logic [DW-1:0]    wd3,
  output logic [15:0]      write_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_r;
  arb_state_t      state_next_s;
  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   ptr_next_s;
  logic [PW-1:0]   pick_idx_s;
  logic [NREQ-1:0] pick_onehot_s;
  logic            grant_s;
  logic            issue_s;
  logic            we3_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_data_s;
  logic [AW-1:0]   wa3_r;
  logic [DW-1:0]   wd3_r;
  logic [15:0]     count_r;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s)
  );

  // Grant decode and selection of the winning requester's address/data.
  always_comb begin
    grant_s    = reset_n & ~hold & (|req_valid);
    sel_addr_s = req_addr[int'(pick_idx_s)*AW +: AW];
    sel_data_s = req_data[int'(pick_idx_s)*DW +: DW];
    ptr_next_s = PW'(rr_next(int'(pick_idx_s), NREQ));
    if (grant_s) begin
      req_ready = pick_onehot_s;
    end else begin
      req_ready = '0;
    end
`ifdef REGFILE_ARB_ZERO_REG_EN
    issue_s = grant_s & (sel_addr_s != '0);
`else
    issue_s = grant_s;
`endif
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: WRITE follows every cycle that registers a write.
  always_comb begin
    case (state_r)
      IDLE:    state_next_s = issue_s ? WRITE : IDLE;
      WRITE:   state_next_s = issue_s ? WRITE : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output: reset_n gates we3 so a write captured just before reset never commits.
  always_comb begin
    case (state_r)
      WRITE:   we3_s = reset_n;
      IDLE:    we3_s = 1'b0;
      default: we3_s = 1'b0;
    endcase
  end

  // Write-port datapath, round-robin pointer and saturating write counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wa3_r    <= '0;
      wd3_r    <= '0;
      rr_ptr_r <= '0;
      count_r  <= 16'd0;
    end else begin
      if (issue_s) begin
        wa3_r <= sel_addr_s;
        wd3_r <= sel_data_s;
      end
      if (grant_s) begin
        rr_ptr_r <= ptr_next_s;
      end
      if (we3_s && (count_r != 16'hFFFF)) begin
        count_r <= count_r + 16'd1;
      end
    end
  end

  assign we3         = we3_s;
  assign wa3         = wa3_r;
  assign wd3         = wd3_r;
  assign write_count = count_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter with a behavioural regfile on the write port.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              hold;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              we3;
  logic [AW-1:0]     wa3;
  logic [DW-1:0]     wd3;
  logic [15:0]       write_count;

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .hold        (hold),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .write_count (write_count)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] rf [32];
  logic          rf_clear;

  always @(posedge clock) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h5A5A_0000 | 32'(i);
    end else if (we3) begin
      rf[wa3] <= wd3;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  wr_req_t       exp_q[$];
  int            tb_ptr  = 0;
  logic [15:0]   exp_cnt = 16'd0;
  bit            started = 1'b0;

  // Model: predicts grant, the next-cycle write and the counter; checked mid-cycle.
  always @(negedge clock) begin
    wr_req_t ent;
    int      gi;
    int      c;
    logic    exp_we;
    if (!reset_n) begin
      check_eq("ready_in_reset", 64'(req_ready), 64'd0);
      check_eq("we3_in_reset", 64'(we3), 64'd0);
      if (started) check_eq("count_before_reset", 64'(write_count), 64'(exp_cnt));
      exp_q.delete();
      exp_cnt = 16'd0;
      tb_ptr  = 0;
      started = 1'b1;
    end else if (started) begin
      check_eq("count", 64'(write_count), 64'(exp_cnt));
      exp_we = (exp_q.size() > 0);
      check_eq("we3", 64'(we3), 64'(exp_we));
      if (exp_we) begin
        ent = exp_q.pop_front();
        check_eq("wa3", 64'(wa3), 64'(ent.addr));
        check_eq("wd3", 64'(wd3), 64'(ent.data));
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
      if (!hold && (req_valid != '0)) begin
        gi = -1;
        for (int k = 0; k < NREQ; k++) begin
          c = (tb_ptr + k) % NREQ;
          if (gi < 0 && (((req_valid >> c) & 2'b01) != 2'b00)) gi = c;
        end
        check_eq("ready_grant", 64'(req_ready), 64'(2'b01 << gi));
        tb_ptr   = (gi + 1) % NREQ;
        ent.addr = AW'(req_addr >> (gi * AW));
        ent.data = DW'(req_data >> (gi * DW));
`ifdef REGFILE_ARB_ZERO_REG_EN
        if (ent.addr != 5'd0) exp_q.push_back(ent);
`else
        exp_q.push_back(ent);
`endif
      end else begin
        check_eq("ready_idle", 64'(req_ready), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    hold      = 1'b0;
    rf_clear  = 1'b1;
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {32'hBBBB_0002, 32'hAAAA_0001};

    // 1. Reset held two cycles with both requesters valid.
    tick();
    rf_clear = 1'b0;
    tick();
    check_eq("rst_we3", 64'(we3), 64'd0);
    check_eq("rst_count", 64'(write_count), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    check_eq("first_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check_eq("first_we3", 64'(we3), 64'd1);
    check_eq("first_wa3", 64'(wa3), 64'd1);
    tick();

    // 2. Single request from req0.
    req_addr  = {5'd2, 5'd5};
    req_data  = {32'hBBBB_0002, 32'hDEAD_BEEF};
    req_valid = 2'b01;
    #1;
    check_eq("single_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check_eq("single_we3", 64'(we3), 64'd1);
    check_eq("single_wa3", 64'(wa3), 64'd5);
    check_eq("single_wd3", 64'(wd3), 64'hDEAD_BEEF);
    tick();
    check_eq("single_rf5", 64'(rf[5]), 64'hDEAD_BEEF);

    // 3. Contention on the same address; pointer starts at 1 so req0 is granted last.
    req_addr  = {5'd9, 5'd9};
    req_data  = {32'hB1B1_0009, 32'hA0A0_0009};
    req_valid = 2'b11;
    repeat (4) tick();
    req_valid = 2'b00;
    check_eq("cont_last_we3", 64'(we3), 64'd1);
    tick();
    check_eq("cont_drain_we3", 64'(we3), 64'd0);
    check_eq("cont_rf9", 64'(rf[9]), 64'hA0A0_0009);
    check_eq("cont_count", 64'(write_count), 64'd6);

    // 4. Hold raised the cycle after a grant.
    req_addr  = {5'd13, 5'd12};
    req_data  = {32'hB0B0_0013, 32'hC0C0_0012};
    req_valid = 2'b01;
    #1;
    check_eq("hold_pre_ready", 64'(req_ready), 64'(2'b01));
    tick();
    hold = 1'b1;
    #1;
    check_eq("hold_inflight_we3", 64'(we3), 64'd1);
    check_eq("hold_inflight_wa3", 64'(wa3), 64'd12);
    check_eq("hold_ready", 64'(req_ready), 64'd0);
    repeat (2) begin
      tick();
      check_eq("hold_we3", 64'(we3), 64'd0);
      check_eq("hold_ready_off", 64'(req_ready), 64'd0);
    end
    hold = 1'b0;
    #1;
    check_eq("hold_release_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    check_eq("hold_release_we3", 64'(we3), 64'd1);
    tick();

    // 5. Reset on the cycle after accepting addr 7.
    req_addr  = {5'd13, 5'd7};
    req_data  = {32'hB0B0_0013, 32'h7777_7777};
    req_valid = 2'b01;
    tick();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    #1;
    check_eq("rst_mid_we3", 64'(we3), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("rst_mid_rf7", 64'(rf[7]), 64'h5A5A_0007);
    check_eq("rst_mid_count", 64'(write_count), 64'd0);
    check_eq("rst_mid_we3_after", 64'(we3), 64'd0);

    // 6. Request to address 0.
    req_addr  = {5'd13, 5'd0};
    req_data  = {32'hB0B0_0013, 32'h0000_0001};
    req_valid = 2'b01;
    #1;
    check_eq("zero_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
`ifdef REGFILE_ARB_ZERO_REG_EN
    check_eq("zero_we3", 64'(we3), 64'd0);
    tick();
    check_eq("zero_count", 64'(write_count), 64'd0);
`else
    check_eq("zero_we3", 64'(we3), 64'd1);
    check_eq("zero_wa3", 64'(wa3), 64'd0);
    check_eq("zero_wd3", 64'(wd3), 64'd1);
    tick();
    check_eq("zero_count", 64'(write_count), 64'd1);
`endif
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
